// File: rtl/keypad_scanner_if.sv
// Keypad bus between the scanner and the matrix/consumer side: rows in, column drive and key report out.
interface keypad_scanner_if;
    logic [3:0] rows;
    logic [3:0] columns;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  rows,
        output columns,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output rows,
        input  columns,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, debounces one key at a time,
// and reports a single key_valid pulse per accepted press with key_held spanning press to release.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic               clk,
    input  logic               rst,
    keypad_scanner_if.master   kbus
);
    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam int unsigned MW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD, ST_RELEASE} state_t;

    state_t        state;
    logic [3:0]    rows_meta;
    logic [3:0]    rows_sync;
    logic [CW-1:0] dwell;
    logic [1:0]    col;
    logic [1:0]    row;
    logic [MW-1:0] count;
    logic [3:0]    columns;
    logic [3:0]    key_code;
    logic          key_valid;
    logic          key_held;

    logic          sample;
    logic          row_low;
    logic [1:0]    low_row;

    assign sample  = (dwell == CW'(SCAN_DIV - 1));
    assign row_low = ~rows_sync[row];

    always_comb begin
        if      (!rows_sync[0]) low_row = 2'd0;
        else if (!rows_sync[1]) low_row = 2'd1;
        else if (!rows_sync[2]) low_row = 2'd2;
        else                    low_row = 2'd3;
    end

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_map = 4'h1;
            4'h1: key_map = 4'h2;
            4'h2: key_map = 4'h3;
            4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;
            4'h5: key_map = 4'h5;
            4'h6: key_map = 4'h6;
            4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;
            4'h9: key_map = 4'h8;
            4'hA: key_map = 4'h9;
            4'hB: key_map = 4'hC;
            4'hC: key_map = 4'h0;
            4'hD: key_map = 4'hF;
            4'hE: key_map = 4'hE;
            4'hF: key_map = 4'hD;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SCAN;
            rows_meta <= '1;
            rows_sync <= '1;
            dwell     <= '0;
            col       <= '0;
            row       <= '0;
            count     <= '0;
            columns   <= 4'b1110;
            key_code  <= 4'hA;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            rows_meta <= kbus.rows;
            rows_sync <= rows_meta;
            key_valid <= 1'b0;
            // Column and state changes only happen on a sample, where the dwell
            // counter wraps anyway, so a free-running wrap restarts it on every change.
            dwell     <= sample ? '0 : dwell + CW'(1);

            if (sample) begin
                case (state)
                    ST_SCAN: begin
                        if (&rows_sync) begin
                            col     <= col + 2'd1;
                            columns <= {columns[2:0], columns[3]};
                        end else begin
                            row   <= low_row;
                            count <= MW'(1);
                            state <= ST_DEBOUNCE;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (row_low) begin
                            if (count == MW'(DEBOUNCE - 1)) begin
                                state     <= ST_HELD;
                                key_code  <= key_map(row, col);
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                count     <= '0;
                            end else begin
                                count <= count + MW'(1);
                            end
                        end else begin
                            state   <= ST_SCAN;
                            count   <= '0;
                            col     <= col + 2'd1;
                            columns <= {columns[2:0], columns[3]};
                        end
                    end
                    ST_HELD: begin
                        if (!row_low) begin
                            count <= MW'(1);
                            state <= ST_RELEASE;
                        end
                    end
                    ST_RELEASE: begin
                        if (!row_low) begin
                            if (count == MW'(DEBOUNCE - 1)) begin
                                state    <= ST_SCAN;
                                key_held <= 1'b0;
                                count    <= '0;
                                col      <= col + 2'd1;
                                columns  <= {columns[2:0], columns[3]};
                            end else begin
                                count <= count + MW'(1);
                            end
                        end else begin
                            state <= ST_HELD;
                            count <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign kbus.columns   = columns;
    assign kbus.key_code  = key_code;
    assign kbus.key_valid = key_valid;
    assign kbus.key_held  = key_held;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: idle column table, hand-timed corner sequences, and random presses/glitches
// judged by a press-level model (one report per stable press, none per short glitch).
module tb_keypad_scanner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] pressed = '0;

    keypad_scanner_if kif ();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk  (clk),
        .rst  (rst),
        .kbus (kif)
    );

    always #5 clk = ~clk;

    // Matrix model: a row reads low when any pressed key on it sits in a driven-low column.
    always_comb begin
        kif.rows = '1;
        for (int r = 0; r < 4; r++)
            if (|(pressed[r*4 +: 4] & ~kif.columns)) kif.rows[r] = 1'b0;
    end

    int tests = 0;
    int failed = 0;
    int k = 0;
    int valid_count = 0;
    logic mon_en = 1'b0;
    logic prev_valid = 1'b0;

    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'h0, 4'hF, 4'hE, 4'hD};

    typedef struct {
        logic [15:0] pressed;
        int          cyc;
        logic [3:0]  columns;
        logic [3:0]  key_code;
        logic        key_valid;
        logic        key_held;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, k);
        end
    endtask

    always @(negedge clk) begin
        if (kif.key_valid === 1'b1) valid_count <= valid_count + 1;
        if (mon_en) begin
            check("one_column_low", $countones(~kif.columns), 1);
            check("valid_not_back_to_back", {31'd0, prev_valid & kif.key_valid}, 0);
        end
        prev_valid <= kif.key_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic run_to(input int n);
        while (k < n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pressed = '0;
        tick();
        tick();
        rst = 1'b0;
        k = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int v0;
        int idx;
        int hold;
        logic [3:0] last_code;

        vecs[0] = '{16'h0,  0, 4'b1110, 4'hA, 1'b0, 1'b0};
        vecs[1] = '{16'h0,  3, 4'b1110, 4'hA, 1'b0, 1'b0};
        vecs[2] = '{16'h0,  4, 4'b1101, 4'hA, 1'b0, 1'b0};
        vecs[3] = '{16'h0,  7, 4'b1101, 4'hA, 1'b0, 1'b0};
        vecs[4] = '{16'h0,  8, 4'b1011, 4'hA, 1'b0, 1'b0};
        vecs[5] = '{16'h0, 12, 4'b0111, 4'hA, 1'b0, 1'b0};
        vecs[6] = '{16'h0, 15, 4'b0111, 4'hA, 1'b0, 1'b0};
        vecs[7] = '{16'h0, 16, 4'b1110, 4'hA, 1'b0, 1'b0};
        vecs[8] = '{16'h0, 20, 4'b1101, 4'hA, 1'b0, 1'b0};

        // Idle scan after reset
        do_reset();
        mon_en = 1'b1;
        v0 = valid_count;
        for (int i = 0; i < 9; i++) begin
            pressed = vecs[i].pressed;
            run_to(vecs[i].cyc);
            check("idle_columns",   {28'd0, kif.columns},  {28'd0, vecs[i].columns});
            check("idle_key_code",  {28'd0, kif.key_code}, {28'd0, vecs[i].key_code});
            check("idle_key_valid", {31'd0, kif.key_valid}, {31'd0, vecs[i].key_valid});
            check("idle_key_held",  {31'd0, kif.key_held},  {31'd0, vecs[i].key_held});
        end
        check("idle_no_valid", valid_count - v0, 0);

        // Row1/column3 held, then released
        do_reset();
        v0 = valid_count;
        pressed[7] = 1'b1;
        run_to(23);
        check("b_before_accept", {31'd0, kif.key_valid}, 0);
        run_to(24);
        check("b_valid_pulse", {31'd0, kif.key_valid}, 1);
        check("b_key_code", {28'd0, kif.key_code}, 32'hB);
        check("b_key_held", {31'd0, kif.key_held}, 1);
        run_to(25);
        check("b_valid_one_cycle", {31'd0, kif.key_valid}, 0);
        run_to(40);
        pressed = '0;
        check("b_single_valid", valid_count - v0, 1);
        run_to(51);
        check("b_held_until_third_release", {31'd0, kif.key_held}, 1);
        run_to(52);
        check("b_held_falls", {31'd0, kif.key_held}, 0);
        check("b_columns_advance", {28'd0, kif.columns}, 32'b1110);

        // Row3/column1 short press: two samples only
        do_reset();
        v0 = valid_count;
        pressed[13] = 1'b1;
        run_to(12);
        pressed = '0;
        run_to(13);
        check("short_columns_hold", {28'd0, kif.columns}, 32'b1101);
        run_to(16);
        check("short_columns_advance", {28'd0, kif.columns}, 32'b1011);
        check("short_not_held", {31'd0, kif.key_held}, 0);
        run_to(40);
        check("short_no_valid", valid_count - v0, 0);
        check("short_code_kept", {28'd0, kif.key_code}, 32'hA);

        // Rows 0 and 2 in column2, then a column0 key while held
        do_reset();
        v0 = valid_count;
        pressed[2] = 1'b1;
        pressed[10] = 1'b1;
        run_to(20);
        check("multi_valid", {31'd0, kif.key_valid}, 1);
        check("multi_lowest_row", {28'd0, kif.key_code}, 32'h3);
        run_to(22);
        pressed[4] = 1'b1;
        run_to(50);
        check("multi_second_ignored", valid_count - v0, 1);
        check("multi_code_kept", {28'd0, kif.key_code}, 32'h3);
        check("multi_still_held", {31'd0, kif.key_held}, 1);
        check("multi_columns_hold", {28'd0, kif.columns}, 32'b1011);

        // Release bounce on row0/column0
        do_reset();
        v0 = valid_count;
        pressed[0] = 1'b1;
        run_to(12);
        check("bounce_accept", {31'd0, kif.key_valid}, 1);
        check("bounce_code", {28'd0, kif.key_code}, 32'h1);
        run_to(14);
        pressed[0] = 1'b0;
        run_to(21);
        pressed[0] = 1'b1;
        run_to(29);
        check("bounce_back_to_held", {31'd0, kif.key_held}, 1);
        run_to(30);
        pressed[0] = 1'b0;
        check("bounce_no_second_valid", valid_count - v0, 1);
        run_to(43);
        check("bounce_release_restarted", {31'd0, kif.key_held}, 1);
        run_to(44);
        check("bounce_release_done", {31'd0, kif.key_held}, 0);
        run_to(50);
        check("bounce_total_valid", valid_count - v0, 1);

        // Reset during debounce of key 5
        do_reset();
        v0 = valid_count;
        pressed[5] = 1'b1;
        run_to(13);
        rst = 1'b1;
        pressed = '0;
        tick();
        rst = 1'b0;
        check("rst_columns", {28'd0, kif.columns}, 32'b1110);
        check("rst_code", {28'd0, kif.key_code}, 32'hA);
        check("rst_valid", {31'd0, kif.key_valid}, 0);
        check("rst_held", {31'd0, kif.key_held}, 0);
        run_to(40);
        check("rst_no_valid", valid_count - v0, 0);

        // Random stable presses and short glitches
        do_reset();
        last_code = 4'hA;
        for (int e = 0; e < 24; e++) begin
            idx = $urandom_range(0, 15);
            v0 = valid_count;
            if ($urandom_range(0, 9) < 7) begin
                hold = $urandom_range(50, 90);
                pressed = '0;
                pressed[idx] = 1'b1;
                repeat (hold) tick();
                check("rand_held_while_pressed", {31'd0, kif.key_held}, 1);
                pressed = '0;
                repeat (40) tick();
                last_code = keymap[idx];
                check("rand_one_valid", valid_count - v0, 1);
                check("rand_code", {28'd0, kif.key_code}, {28'd0, last_code});
                check("rand_released", {31'd0, kif.key_held}, 0);
            end else begin
                hold = $urandom_range(1, 3);
                pressed = '0;
                pressed[idx] = 1'b1;
                repeat (hold) tick();
                pressed = '0;
                repeat (30) tick();
                check("glitch_no_valid", valid_count - v0, 0);
                check("glitch_code_kept", {28'd0, kif.key_code}, {28'd0, last_code});
                check("glitch_not_held", {31'd0, kif.key_held}, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
